dpd_stream_packer: RTL and testbench

DPD_STREAM_PACKER -- requirements
Module: dpd_stream_packer

---
 rtl/dpd_stream_packer.sv | 121 ++++++++++++
 tb/tb_dpd_stream_packer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dpd_stream_packer.sv
// Packs a stream of BCD digits into 10-bit densely-packed-decimal declets, three digits per group.
// Optional: define DPD_DIGIT_CHECK_EN to zero out non-BCD digits and flag the declet through out_err.
`timescale 1ns/1ps
module dpd_stream_packer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in_digit,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [9:0] out_dpd,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       out_err,
  output logic       busy
);

  // IEEE 754-2008 BCD->DPD encoder; the case key is the "large digit" flag of each digit.
  function automatic logic [9:0] dpd_pack(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    logic [9:0] r;
    case ({h[3], t[3], o[3]})
      3'b000:  r = {h[2:0], t[2:0], 1'b0, o[2:0]};
      3'b001:  r = {h[2:0], t[2:0], 1'b1, 2'b00, o[0]};
      3'b010:  r = {h[2:0], o[2:1], t[0], 1'b1, 2'b01, o[0]};
      3'b100:  r = {o[2:1], h[0], t[2:0], 1'b1, 2'b10, o[0]};
      3'b110:  r = {o[2:1], h[0], 2'b00, t[0], 1'b1, 2'b11, o[0]};
      3'b101:  r = {t[2:1], h[0], 2'b01, t[0], 1'b1, 2'b11, o[0]};
      3'b011:  r = {h[2:0], 2'b10, t[0], 1'b1, 2'b11, o[0]};
      default: r = {2'b00, h[0], 2'b11, t[0], 1'b1, 2'b11, o[0]};
    endcase
    return r;
  endfunction

  logic [3:0] dig_reg  [3];
  logic [3:0] dig_next [3];
  logic [3:0] shf      [3];
  logic [1:0] cnt_reg, cnt_next;
  logic [3:0] digit_c;
  logic       accept, close;
  logic       out_valid_reg;
  logic [9:0] out_dpd_reg;
  logic       out_last_reg;

  assign in_ready = ~out_valid_reg | out_ready;
  assign accept   = in_valid & in_ready;
  assign close    = accept & ((cnt_reg == 2'd2) | in_last);

  // Lane 2 is the hundreds digit; clearing on close makes short groups left-pad with zeros.
  assign shf[2] = dig_reg[1];
  assign shf[1] = dig_reg[0];
  assign shf[0] = digit_c;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      assign dig_next[gi] = close ? 4'd0 : (accept ? shf[gi] : dig_reg[gi]);
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dig_reg[gi] <= 4'd0;
        else        dig_reg[gi] <= dig_next[gi];
      end
    end
  endgenerate

  always_comb begin
    cnt_next = cnt_reg;
    if (close)       cnt_next = 2'd0;
    else if (accept) cnt_next = cnt_reg + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg       <= 2'd0;
      out_valid_reg <= 1'b0;
      out_dpd_reg   <= 10'd0;
      out_last_reg  <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      // A close while the consumer takes the old declet reloads with no bubble.
      if (close) begin
        out_valid_reg <= 1'b1;
        out_dpd_reg   <= dpd_pack(shf[2], shf[1], shf[0]);
        out_last_reg  <= in_last;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

`ifdef DPD_DIGIT_CHECK_EN
  logic digit_bad;
  logic grp_err_reg;
  logic out_err_reg;

  assign digit_bad = (in_digit > 4'd9);
  assign digit_c   = digit_bad ? 4'd0 : in_digit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp_err_reg <= 1'b0;
      out_err_reg <= 1'b0;
    end else if (close) begin
      out_err_reg <= grp_err_reg | digit_bad;
      grp_err_reg <= 1'b0;
    end else if (accept && digit_bad) begin
      grp_err_reg <= 1'b1;
    end
  end

  assign out_err = out_err_reg;
`else
  assign digit_c = in_digit;
  assign out_err = 1'b0;
`endif

  assign out_valid = out_valid_reg;
  assign out_dpd   = out_dpd_reg;
  assign out_last  = out_last_reg;
  assign busy      = (cnt_reg != 2'd0) | out_valid_reg;

endmodule

// File: tb/tb_dpd_stream_packer.sv
// Randomized and directed bench for dpd_stream_packer against a digit-queue reference model.
// The encoding table is derived by inverting an independent DPD decoder.
`timescale 1ns/1ps
module tb_dpd_stream_packer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_digit;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [9:0] out_dpd;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       out_err;
  logic       busy;

  always #5 clk = ~clk;

  dpd_stream_packer dut (
    .clk(clk), .rst_n(rst_n),
    .in_digit(in_digit), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_dpd(out_dpd), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_err(out_err), .busy(busy)
  );

  int total = 0;
  int bad   = 0;
  int enc_tab [1000];

  // Reference model state: digits of the open group, and the declet the DUT should be holding.
  int         grp_q[$];
  bit         grp_err;
  bit         exp_valid;
  logic [9:0] exp_dpd;
  bit         exp_last;
  bit         exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Decoder written straight from the DPD decode table (bits p q r s t u v w x y).
  function automatic int dpd_decode(input logic [9:0] c);
    int d2, d1, d0;
    int pqr, stu, wxy;
    pqr = int'(c[9:7]); stu = int'(c[6:4]); wxy = int'(c[2:0]);
    if (!c[3]) begin
      d2 = pqr; d1 = stu; d0 = wxy;
    end else begin
      case (c[2:1])
        2'b00: begin d2 = pqr; d1 = stu; d0 = 8 + int'(c[0]); end
        2'b01: begin d2 = pqr; d1 = 8 + int'(c[4]); d0 = int'({c[6:5], c[0]}); end
        2'b10: begin d2 = 8 + int'(c[7]); d1 = stu; d0 = int'({c[9:8], c[0]}); end
        default: begin
          case (c[6:5])
            2'b00: begin d2 = 8 + int'(c[7]); d1 = 8 + int'(c[4]); d0 = int'({c[9:8], c[0]}); end
            2'b01: begin d2 = 8 + int'(c[7]); d1 = int'({c[9:8], c[4]}); d0 = 8 + int'(c[0]); end
            2'b10: begin d2 = pqr; d1 = 8 + int'(c[4]); d0 = 8 + int'(c[0]); end
            default: begin d2 = 8 + int'(c[7]); d1 = 8 + int'(c[4]); d0 = 8 + int'(c[0]); end
          endcase
        end
      endcase
    end
    return d2 * 100 + d1 * 10 + d0;
  endfunction

  function automatic int pick_digit();
`ifdef DPD_DIGIT_CHECK_EN
    return ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
`else
    return int'($urandom_range(0, 9));
`endif
  endfunction

  task automatic model_clear();
    grp_q.delete();
    grp_err   = 1'b0;
    exp_valid = 1'b0;
  endtask

  // One clock of stimulus: checks at the falling edge, then advances the model.
  task automatic step(input logic v, input logic [3:0] d, input logic l, input logic r);
    bit acc, closed;
    int val;
    in_valid = v; in_digit = d; in_last = l; out_ready = r;
    @(negedge clk);
    chk("out_valid", out_valid, exp_valid);
    chk("in_ready", in_ready, (!exp_valid || r));
    chk("busy", busy, (grp_q.size() != 0) || exp_valid);
    if (exp_valid) begin
      chk("out_dpd", out_dpd, exp_dpd);
      chk("out_last", out_last, exp_last);
      chk("out_err", out_err, exp_err);
    end
    acc = v && (!exp_valid || r);
    closed = 1'b0;
    if (acc) begin
`ifdef DPD_DIGIT_CHECK_EN
      if (d > 4'd9) begin grp_q.push_back(0); grp_err = 1'b1; end
      else grp_q.push_back(int'(d));
`else
      grp_q.push_back(int'(d));
`endif
      if (grp_q.size() == 3 || l) begin
        val = 0;
        foreach (grp_q[i]) val = val * 10 + grp_q[i];
        exp_dpd   = 10'(enc_tab[val]);
        exp_last  = l;
        exp_err   = grp_err;
        exp_valid = 1'b1;
        grp_q.delete();
        grp_err = 1'b0;
        closed  = 1'b1;
      end
    end
    if (!closed && exp_valid && r) exp_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    in_valid = 1'b0; in_last = 1'b0; in_digit = 4'd0; out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_dpd", out_dpd, 0);
    chk("rst_last", out_last, 0);
    chk("rst_err", out_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1000; i++) enc_tab[i] = -1;
    // Canonical codes have p,q = 0 where a choice exists, so the lowest code for each value wins.
    for (int c = 0; c < 1024; c++) begin
      int v;
      v = dpd_decode(10'(c));
      if (enc_tab[v] < 0) enc_tab[v] = c;
    end

    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_digit = 4'd0; out_ready = 1'b0;
    model_clear();
    @(posedge clk); #1;
    reset_pulse();

    // 1,2,3 closed by in_last
    step(1, 4'd1, 0, 1); step(1, 4'd2, 0, 1); step(1, 4'd3, 1, 1);
    chk("d123_dpd", out_dpd, 10'h0A3);
    chk("d123_valid", out_valid, 1);
    chk("d123_last", out_last, 1);

    // 9,9,9 full group, then short group 4,5
    step(1, 4'd9, 0, 1); step(1, 4'd9, 0, 1); step(1, 4'd9, 0, 1);
    chk("d999_dpd", out_dpd, 10'h0FF);
    chk("d999_last", out_last, 0);
    step(1, 4'd4, 0, 1); step(1, 4'd5, 1, 1);
    chk("d45_dpd", out_dpd, 10'h045);
    chk("d45_last", out_last, 1);

    // single-digit groups back to back
    step(1, 4'd7, 1, 1);
    chk("d7_dpd", out_dpd, 10'h007);
    step(1, 4'd8, 1, 1);
    chk("b2b_valid", out_valid, 1);
    chk("b2b_dpd", out_dpd, 10'h008);

    // backpressure holds the declet and stalls input
    step(0, 4'd0, 0, 1);
    step(1, 4'd2, 1, 0);
    step(1, 4'd3, 1, 0);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_dpd", out_dpd, 10'h002);
    step(1, 4'd3, 1, 1);
    chk("bp_next_dpd", out_dpd, 10'h003);
    chk("bp_next_valid", out_valid, 1);

    // reset mid-group discards the partial group
    step(0, 4'd0, 0, 1);
    step(1, 4'd1, 0, 1); step(1, 4'd2, 0, 1);
    reset_pulse();
    step(1, 4'd3, 1, 1);
    chk("rstmid_dpd", out_dpd, 10'h003);

`ifdef DPD_DIGIT_CHECK_EN
    step(1, 4'hA, 0, 1); step(1, 4'd1, 0, 1); step(1, 4'd2, 1, 1);
    chk("bad_dpd", out_dpd, 10'h012);
    chk("bad_err", out_err, 1);
    step(1, 4'd1, 0, 1); step(1, 4'd2, 0, 1); step(1, 4'd3, 1, 1);
    chk("clean_err", out_err, 0);
`endif

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) reset_pulse();
      step($urandom_range(0, 9) < 7, 4'(pick_digit()), $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) < 6);
    end
    repeat (3) step(0, 4'd0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
